nmac_cmd_frame_parser: RTL and testbench

Host-side configuration frame parser sitting directly upstream of the command parse/encapsulate stage in the host input path. It accepts NMAC configuration frames as a 134-bit word stream, checks the Ethernet/NMAC header, and unpacks the 64-bit commands carried in the payload. Each command is issued as a single-cycle register write or read (19-bit address, fixed-address flag, 32-bit data) on the bus that the downstream stage consumes. Per-frame bookkeeping and error counters are exported for status readout.

---
 rtl/nmac_cmd_frame_parser_if.sv | 29 ++
 rtl/nmac_cmd_frame_parser.sv | 207 ++++++++++++++++++++
 tb/tb_nmac_cmd_frame_parser.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nmac_cmd_frame_parser_if.sv
// nmac_cmd_frame_parser_if
//   Bundles the two buses around the NMAC command frame parser:
//   - frame stream in : iv_data, i_data_wr, o_data_ready
//   - register bus out: o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata
//   The slave modport is the parser's view.
//   The master modport is the view of the host logic, which feeds frames
//   and consumes register commands.
//   Signal names keep their parser-side direction prefixes so that the
//   names match the status and register documentation.
interface nmac_cmd_frame_parser_if;
  logic [133:0] iv_data;
  logic         i_data_wr;
  logic         o_data_ready;
  logic         o_wr;
  logic         o_rd;
  logic [18:0]  ov_addr;
  logic         o_addr_fixed;
  logic [31:0]  ov_wdata;

  modport slave (
    input  iv_data, i_data_wr,
    output o_data_ready, o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata
  );

  modport master (
    output iv_data, i_data_wr,
    input  o_data_ready, o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata
  );
endinterface

// File: rtl/nmac_cmd_frame_parser.sv
// nmac_cmd_frame_parser
//   Accepts NMAC configuration frames as a 134-bit word stream. It checks
//   the head word's ethertype and command type, then unpacks the 64-bit
//   commands in the middle and tail words into single-cycle register
//   write/read strobes.
//
//   Ports:
//     i_clk        sole clock
//     i_rst        synchronous active-high reset
//     bus          nmac_cmd_frame_parser_if.slave, which carries:
//                    - the frame stream (iv_data, i_data_wr, o_data_ready)
//                    - the register bus (o_wr, o_rd, ov_addr, o_addr_fixed,
//                      ov_wdata)
//     ov_frm_cnt   frames that passed the header check (wraps)
//     ov_err_cnt   malformed or rejected frames (wraps)
module nmac_cmd_frame_parser #(
  parameter logic [15:0] P_ETHERTYPE = 16'h1662,
  parameter logic [7:0]  P_CMD_TYPE  = 8'h01
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  nmac_cmd_frame_parser_if.slave        bus,
  output logic [15:0]                   ov_frm_cnt,
  output logic [15:0]                   ov_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PARSE,
    S_DRAIN,
    S_DISCARD
  } state_t;

  // Command with the reserved bits stripped: op, fixed flag, address, data.
  typedef struct packed {
    logic [1:0]  op;
    logic        fixed;
    logic [18:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RD    = 2'b10;

  state_t       state_q, state_d;
  logic [7:0]   left_q, left_d;
  cmd_t         cmd1_q, cmd1_d;
  logic         drain_tail_q, drain_tail_d;
  logic [7:0]   left_after0;
  logic         take0, take1;
  logic         frm_inc, err_abandon, err_reject;
  logic         emit_v;
  cmd_t         emit_cmd;

  logic [1:0]   tag;
  logic [3:0]   vb;
  logic [127:0] pl;
  logic         accept;
  logic         is_head, is_mid, is_tail;
  logic         hdr_ok, cmd0_ok, cmd1_ok;
  cmd_t         cmd0_f, cmd1_f;
  logic         unused_reserved;

  assign tag = bus.iv_data[133:132];
  assign vb  = bus.iv_data[131:128];
  assign pl  = bus.iv_data[127:0];

  assign bus.o_data_ready = (state_q != S_DRAIN);
  assign accept           = bus.i_data_wr & bus.o_data_ready;

  assign is_head = (tag == TAG_HEAD);
  assign is_mid  = (tag == TAG_MID);
  assign is_tail = (tag == TAG_TAIL);

  assign hdr_ok = (pl[31:16] == P_ETHERTYPE) && (pl[15:8] == P_CMD_TYPE);

  // A tail word with 0 valid bytes means a full 16 bytes, so both commands
  // are present. With 8..15 valid bytes only the upper command is complete.
  assign cmd0_ok = is_mid | (is_tail & ((vb == 4'd0) | (vb >= 4'd8)));
  assign cmd1_ok = is_mid | (is_tail & (vb == 4'd0));

  assign cmd0_f = {pl[127:125], pl[114:64]};
  assign cmd1_f = {pl[63:61],   pl[50:0]};

  // The reserved command bits are carried but never interpreted.
  assign unused_reserved = ^{pl[124:115], pl[60:51]};

  // Next-state and command selection.
  // When a middle or tail word is accepted in PARSE, its upper command is
  // issued on the next edge. The lower command is parked in cmd1_q, and a
  // single DRAIN cycle issues it, so that the register bus sees at most one
  // command per cycle. Each command that is consumed, including a nop,
  // decrements the remaining count when its word is accepted.
  // A head word that arrives outside IDLE means the previous frame lost its
  // tail. That frame is counted as an error, and the head is then judged
  // exactly as it would be in IDLE.
  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    cmd1_d       = cmd1_q;
    drain_tail_d = drain_tail_q;
    left_after0  = left_q;
    take0        = 1'b0;
    take1        = 1'b0;
    frm_inc      = 1'b0;
    err_abandon  = 1'b0;
    err_reject   = 1'b0;
    emit_v       = 1'b0;
    emit_cmd     = '0;

    if (state_q == S_DRAIN) begin
      emit_v   = 1'b1;
      emit_cmd = cmd1_q;
      if (drain_tail_q)
        state_d = S_IDLE;
      else if (left_q == 8'd0)
        state_d = S_DISCARD;
      else
        state_d = S_PARSE;
    end else if (accept) begin
      if (is_head) begin
        err_abandon = (state_q != S_IDLE);
        if (hdr_ok) begin
          left_d  = pl[7:0];
          frm_inc = 1'b1;
          state_d = S_PARSE;
        end else begin
          err_reject = 1'b1;
          state_d    = S_DISCARD;
        end
      end else if (is_mid | is_tail) begin
        case (state_q)
          S_IDLE: begin
            err_reject = 1'b1;
          end
          S_DISCARD: begin
            if (is_tail)
              state_d = S_IDLE;
          end
          S_PARSE: begin
            take0       = cmd0_ok && (left_q != 8'd0);
            left_after0 = left_q - {7'd0, take0};
            take1       = cmd1_ok && take0 && (left_after0 != 8'd0);
            left_d      = left_after0 - {7'd0, take1};
            emit_v      = take0;
            emit_cmd    = cmd0_f;
            if (take1) begin
              cmd1_d       = cmd1_f;
              drain_tail_d = is_tail;
              state_d      = S_DRAIN;
            end else if (is_tail) begin
              state_d = S_IDLE;
            end else if (left_d == 8'd0) begin
              state_d = S_DISCARD;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      // An untagged word (2'b00) is consumed and has no effect.
    end
  end

  // State, counters and the registered register-bus outputs.
  // Address, flag and data are forced to zero whenever no strobe is driven,
  // so a nop leaves the bus completely quiet. Read commands never expose
  // their data field.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= S_IDLE;
      left_q           <= 8'd0;
      cmd1_q           <= '0;
      drain_tail_q     <= 1'b0;
      ov_frm_cnt       <= 16'd0;
      ov_err_cnt       <= 16'd0;
      bus.o_wr         <= 1'b0;
      bus.o_rd         <= 1'b0;
      bus.ov_addr      <= 19'd0;
      bus.o_addr_fixed <= 1'b0;
      bus.ov_wdata     <= 32'd0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      cmd1_q       <= cmd1_d;
      drain_tail_q <= drain_tail_d;
      ov_frm_cnt   <= ov_frm_cnt + {15'd0, frm_inc};
      ov_err_cnt   <= ov_err_cnt + {15'd0, err_abandon} + {15'd0, err_reject};
      bus.o_wr     <= emit_v && (emit_cmd.op == OP_WR);
      bus.o_rd     <= emit_v && (emit_cmd.op == OP_RD);
      if (emit_v && ((emit_cmd.op == OP_WR) || (emit_cmd.op == OP_RD))) begin
        bus.ov_addr      <= emit_cmd.addr;
        bus.o_addr_fixed <= emit_cmd.fixed;
        bus.ov_wdata     <= (emit_cmd.op == OP_WR) ? emit_cmd.data : 32'd0;
      end else begin
        bus.ov_addr      <= 19'd0;
        bus.o_addr_fixed <= 1'b0;
        bus.ov_wdata     <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_nmac_cmd_frame_parser.sv
// tb_nmac_cmd_frame_parser
//   Directed frames with hand-computed register strobes and counters for
//   nmac_cmd_frame_parser. A negedge monitor logs every strobe, with the
//   cycle in which it appears, so that the scenarios can check the order,
//   the contents and the latency of each command.
module tb_nmac_cmd_frame_parser;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] RD   = 2'b10;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;

  nmac_cmd_frame_parser_if bus();

  nmac_cmd_frame_parser #(
    .P_ETHERTYPE (16'h1662),
    .P_CMD_TYPE  (8'h01)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .ov_frm_cnt (frm_cnt),
    .ov_err_cnt (err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic        fixed;
    logic [31:0] wdata;
    int          cyc;
  } strobe_t;

  strobe_t log_q[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle, check that the strobes are exclusive and that the bus is
  // quiet between commands, and log each strobe that appears.
  always @(negedge i_clk) begin
    checkOutput("strobe_excl", 64'(bus.o_wr & bus.o_rd), 64'd0);
    if (bus.o_wr | bus.o_rd)
      log_q.push_back('{bus.o_wr, bus.ov_addr, bus.o_addr_fixed, bus.ov_wdata, cyc});
    else
      checkOutput("idle_bus_zero", {12'd0, bus.ov_addr, bus.o_addr_fixed, bus.ov_wdata}, 64'd0);
  end

  function automatic logic [63:0] mkCmd(input logic [1:0] op, input logic fixed,
                                        input logic [18:0] addr, input logic [31:0] data);
    return {op, fixed, 10'd0, addr, data};
  endfunction

  function automatic logic [127:0] mkHead(input logic [15:0] eth, input logic [7:0] typ,
                                          input logic [7:0] n);
    return {48'h0011_2233_4455, 48'h6677_8899_AABB, eth, typ, n};
  endfunction

  // Drive one word from a negedge and hold it until a rising edge accepts
  // it. Returns how many cycles it waited on ready and the cycle index of
  // the accepting edge.
  task automatic applyStimulus(input logic [1:0] tag, input logic [3:0] vb,
                               input logic [127:0] pl, output int stalls, output int acc);
    stalls = 0;
    @(negedge i_clk);
    bus.iv_data   = {tag, vb, pl};
    bus.i_data_wr = 1'b1;
    while (!bus.o_data_ready && stalls < 8) begin
      @(negedge i_clk);
      stalls++;
    end
    if (!bus.o_data_ready)
      checkOutput("ready_timeout", 64'(bus.o_data_ready), 64'd1);
    @(posedge i_clk);
    #1;
    acc = cyc;
    bus.i_data_wr = 1'b0;
  endtask

  task automatic expectCmd(input string tag, input logic wr, input logic [18:0] addr,
                           input logic fixed, input logic [31:0] wdata, output int c);
    strobe_t s;
    c = -1;
    checkOutput({tag, "_present"}, 64'(log_q.size() != 0), 64'd1);
    if (log_q.size() != 0) begin
      s = log_q.pop_front();
      checkOutput({tag, "_wr"},    64'(s.wr),    64'(wr));
      checkOutput({tag, "_addr"},  64'(s.addr),  64'(addr));
      checkOutput({tag, "_fixed"}, 64'(s.fixed), 64'(fixed));
      checkOutput({tag, "_wdata"}, 64'(s.wdata), 64'(wdata));
      c = s.cyc;
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    int st, acc, st2, acc2, c0, c1, c2;
    i_rst         = 1'b1;
    bus.i_data_wr = 1'b0;
    bus.iv_data   = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    checkOutput("rst_wr",    64'(bus.o_wr), 64'd0);
    checkOutput("rst_rd",    64'(bus.o_rd), 64'd0);
    checkOutput("rst_addr",  64'(bus.ov_addr), 64'd0);
    checkOutput("rst_fixed", 64'(bus.o_addr_fixed), 64'd0);
    checkOutput("rst_wdata", 64'(bus.ov_wdata), 64'd0);
    checkOutput("rst_frm",   64'(frm_cnt), 64'd0);
    checkOutput("rst_err",   64'(err_cnt), 64'd0);
    checkOutput("rst_ready", 64'(bus.o_data_ready), 64'd1);

    // A bad ethertype rejects the frame, and its words issue nothing.
    applyStimulus(HEAD, 4'd0, mkHead(16'h0800, 8'h01, 8'd2), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b0, 19'h5, 32'h5), mkCmd(WR, 1'b0, 19'h6, 32'h6)}, st, acc);
    applyStimulus(TAIL, 4'd0, {mkCmd(WR, 1'b0, 19'h7, 32'h7), mkCmd(WR, 1'b0, 19'h8, 32'h8)}, st, acc);
    settle();
    checkOutput("bad_eth_nocmd", 64'(log_q.size()), 64'd0);
    checkOutput("bad_eth_frm",   64'(frm_cnt), 64'd0);
    checkOutput("bad_eth_err",   64'(err_cnt), 64'd1);

    // Basic frame with N=3. The strobes land in three consecutive cycles,
    // and the tail word waits one cycle for the DRAIN.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd3), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b1, 19'h10, 32'hA5A5A5A5),
                               mkCmd(RD, 1'b1, 19'h17, 32'hDEADBEEF)}, st, acc);
    checkOutput("s1_mid_stall", 64'(st), 64'd0);
    applyStimulus(TAIL, 4'd0, {mkCmd(WR, 1'b0, 19'h1F, 32'h1),
                               mkCmd(2'b11, 1'b0, 19'h0, 32'h0)}, st2, acc2);
    checkOutput("s1_tail_stall", 64'(st2), 64'd1);
    settle();
    expectCmd("s1_c0", 1'b1, 19'h10, 1'b1, 32'hA5A5A5A5, c0);
    expectCmd("s1_c1", 1'b0, 19'h17, 1'b1, 32'h0, c1);
    expectCmd("s1_c2", 1'b1, 19'h1F, 1'b0, 32'h1, c2);
    checkOutput("s1_lat0",  64'(c0), 64'(acc));
    checkOutput("s1_gap01", 64'(c1 - c0), 64'd1);
    checkOutput("s1_gap12", 64'(c2 - c1), 64'd1);
    checkOutput("s1_lat2",  64'(c2), 64'(acc2));
    checkOutput("s1_extra", 64'(log_q.size()), 64'd0);
    checkOutput("s1_frm",   64'(frm_cnt), 64'd1);
    checkOutput("s1_err",   64'(err_cnt), 64'd1);

    // N=1 with a two-write middle word: only cmd0 is issued, there is no
    // DRAIN, and the rest is discarded up to the tail.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd1), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b0, 19'h20, 32'h20), mkCmd(WR, 1'b0, 19'h21, 32'h21)}, st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b0, 19'h22, 32'h22), mkCmd(WR, 1'b0, 19'h23, 32'h23)}, st, acc);
    checkOutput("s3_no_drain", 64'(st), 64'd0);
    applyStimulus(TAIL, 4'd0, {mkCmd(WR, 1'b0, 19'h24, 32'h24), mkCmd(WR, 1'b0, 19'h25, 32'h25)}, st, acc);
    settle();
    expectCmd("s3_c0", 1'b1, 19'h20, 1'b0, 32'h20, c0);
    checkOutput("s3_extra", 64'(log_q.size()), 64'd0);
    checkOutput("s3_frm",   64'(frm_cnt), 64'd2);

    // A tail with 8 valid bytes carries cmd0 only. A tail with 4 valid
    // bytes carries nothing.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd4), st, acc);
    applyStimulus(TAIL, 4'd8, {mkCmd(WR, 1'b0, 19'h30, 32'h3030), mkCmd(WR, 1'b0, 19'h31, 32'h3131)}, st, acc);
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd4), st, acc);
    checkOutput("s4_head_stall", 64'(st), 64'd0);
    applyStimulus(TAIL, 4'd4, {mkCmd(WR, 1'b0, 19'h40, 32'h40), mkCmd(WR, 1'b0, 19'h41, 32'h41)}, st, acc);
    settle();
    expectCmd("s4_c0", 1'b1, 19'h30, 1'b0, 32'h3030, c0);
    checkOutput("s4_extra", 64'(log_q.size()), 64'd0);
    checkOutput("s4_frm",   64'(frm_cnt), 64'd4);
    checkOutput("s4_err",   64'(err_cnt), 64'd1);

    // A second head arrives mid-frame. The old frame is an error, the new
    // frame parses normally, and a stray middle word in IDLE is an error.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd4), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b0, 19'h50, 32'h5050), mkCmd(WR, 1'b0, 19'h51, 32'h5151)}, st, acc);
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd2), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(RD, 1'b0, 19'h60, 32'hFFFFFFFF), mkCmd(WR, 1'b1, 19'h61, 32'h12345678)}, st, acc);
    applyStimulus(TAIL, 4'd0, {mkCmd(2'b11, 1'b0, 19'h0, 32'h0), mkCmd(2'b00, 1'b0, 19'h0, 32'h0)}, st, acc);
    settle();
    expectCmd("s5_c0", 1'b1, 19'h50, 1'b0, 32'h5050, c0);
    expectCmd("s5_c1", 1'b1, 19'h51, 1'b0, 32'h5151, c0);
    expectCmd("s5_c2", 1'b0, 19'h60, 1'b0, 32'h0, c0);
    expectCmd("s5_c3", 1'b1, 19'h61, 1'b1, 32'h12345678, c0);
    checkOutput("s5_extra", 64'(log_q.size()), 64'd0);
    checkOutput("s5_frm",   64'(frm_cnt), 64'd6);
    checkOutput("s5_err",   64'(err_cnt), 64'd2);
    applyStimulus(MID, 4'd0, {mkCmd(WR, 1'b0, 19'h66, 32'h66), mkCmd(WR, 1'b0, 19'h67, 32'h67)}, st, acc);
    settle();
    checkOutput("stray_err",   64'(err_cnt), 64'd3);
    checkOutput("stray_nocmd", 64'(log_q.size()), 64'd0);

    // A nop emits nothing but still uses up one of the N commands.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd3), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(2'b00, 1'b1, 19'h7F, 32'h7F), mkCmd(WR, 1'b0, 19'h55, 32'h55)}, st, acc);
    applyStimulus(TAIL, 4'd0, {mkCmd(WR, 1'b0, 19'h56, 32'h56), mkCmd(WR, 1'b0, 19'h57, 32'h57)}, st, acc);
    settle();
    expectCmd("nop_c0", 1'b1, 19'h55, 1'b0, 32'h55, c0);
    expectCmd("nop_c1", 1'b1, 19'h56, 1'b0, 32'h56, c0);
    checkOutput("nop_extra", 64'(log_q.size()), 64'd0);
    checkOutput("nop_frm",   64'(frm_cnt), 64'd7);

    // Reset during DRAIN: the parked cmd1 is lost, the counters clear, and
    // the tail that follows is an error in IDLE.
    applyStimulus(HEAD, 4'd0, mkHead(16'h1662, 8'h01, 8'd2), st, acc);
    applyStimulus(MID,  4'd0, {mkCmd(WR, 1'b0, 19'h70, 32'h70), mkCmd(WR, 1'b0, 19'h71, 32'h71)}, st, acc);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    checkOutput("rst6_frm",   64'(frm_cnt), 64'd0);
    checkOutput("rst6_err",   64'(err_cnt), 64'd0);
    checkOutput("rst6_ready", 64'(bus.o_data_ready), 64'd1);
    settle();
    expectCmd("rst6_c0", 1'b1, 19'h70, 1'b0, 32'h70, c0);
    checkOutput("rst6_no_cmd1", 64'(log_q.size()), 64'd0);
    applyStimulus(TAIL, 4'd0, {mkCmd(WR, 1'b0, 19'h72, 32'h72), mkCmd(WR, 1'b0, 19'h73, 32'h73)}, st, acc);
    settle();
    checkOutput("rst6_tail_err",   64'(err_cnt), 64'd1);
    checkOutput("rst6_tail_frm",   64'(frm_cnt), 64'd0);
    checkOutput("rst6_tail_nocmd", 64'(log_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
